// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared constants for the UART frame sequencer
package uart_pkg;
  typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_PLD, ST_CHK, ST_DRAIN} state_t;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int CHK_W = 8;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload storage, one synchronous write port and one asynchronous read port
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: hunts HEADER, buffers LEN payload bytes, verifies the additive checksum
// and replays good payloads on a valid/ready stream; bad frames raise a single error pulse.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W = 18
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_tout,
  output logic       err_ovr,
  output logic       busy
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  state_t r_state;
  logic [IW-1:0] r_len, r_wr_idx, r_rd_idx;
  logic [CHK_W-1:0] r_sum;
  logic [CNT_W-1:0] r_tcnt;
  logic r_frame_ok, r_err_len, r_err_chk, r_err_tout, r_err_ovr;
  logic [7:0] w_rdata;
  logic w_active, w_tout, w_len_ok, w_last;
  assign w_active = (r_state == ST_LEN) || (r_state == ST_PLD) || (r_state == ST_CHK);
  // a byte arriving on the terminal count wins over the timeout
  assign w_tout = w_active && !rx_done && (r_tcnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_len_ok = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_LEN));
  assign w_last = r_rd_idx == r_len - IW'(1);
  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk(sys_clk),
    .i_we(r_state == ST_PLD && rx_done),
    .i_waddr(r_wr_idx[AW-1:0]),
    .i_wdata(rx_byte),
    .i_raddr(r_rd_idx[AW-1:0]),
    .o_rdata(w_rdata)
  );
  assign out_valid = r_state == ST_DRAIN;
  assign out_data = out_valid ? w_rdata : 8'd0;
  assign out_last = out_valid && w_last;
  assign busy = r_state != ST_HUNT;
  assign frame_ok = r_frame_ok;
  assign err_len = r_err_len;
  assign err_chk = r_err_chk;
  assign err_tout = r_err_tout;
  assign err_ovr = r_err_ovr;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      r_state <= ST_HUNT;
      r_len <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_sum <= '0;
      r_tcnt <= '0;
      {r_frame_ok, r_err_len, r_err_chk, r_err_tout, r_err_ovr} <= '0;
    end else begin
      {r_frame_ok, r_err_len, r_err_chk, r_err_tout, r_err_ovr} <= '0;
      r_tcnt <= (rx_done || !w_active || w_tout) ? '0 : r_tcnt + CNT_W'(1);
      case (r_state)
        ST_HUNT: if (rx_done && rx_byte == HEADER) r_state <= ST_LEN;
        ST_LEN:
          if (rx_done) begin
            if (w_len_ok) begin
              r_len <= rx_byte[IW-1:0];
              r_sum <= rx_byte;
              r_wr_idx <= '0;
              r_state <= ST_PLD;
            end else begin
              r_err_len <= 1'b1;
              r_state <= ST_HUNT;
            end
          end
        ST_PLD:
          if (rx_done) begin
            r_sum <= r_sum + rx_byte;
            r_wr_idx <= r_wr_idx + IW'(1);
            if (r_wr_idx == r_len - IW'(1)) r_state <= ST_CHK;
          end
        ST_CHK:
          if (rx_done) begin
            if (rx_byte == r_sum) begin
              r_frame_ok <= 1'b1;
              r_rd_idx <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_err_chk <= 1'b1;
              r_state <= ST_HUNT;
            end
          end
        ST_DRAIN: begin
          r_err_ovr <= rx_done;
          if (out_ready) begin
            r_rd_idx <= r_rd_idx + IW'(1);
            if (w_last) r_state <= ST_HUNT;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
      if (w_tout) begin
        r_err_tout <= 1'b1;
        r_state <= ST_HUNT;
      end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames checked every cycle against a queue-based frame model
module tb_uart_rx_frame_ctrl;
  localparam int MAXL = 16;
  localparam int TOUT = 50;
  logic sys_clk = 0, rst = 1, rx_done = 0, out_ready = 1, tog = 0;
  logic [7:0] rx_byte = 8'hA5;
  logic [7:0] out_data;
  logic out_valid, out_last, frame_ok, err_len, err_chk, err_tout, err_ovr, busy;
  always #5 sys_clk = ~sys_clk;
  uart_rx_frame_ctrl #(.HEADER(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYC(TOUT), .CNT_W(18)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .err_len(err_len), .err_chk(err_chk), .err_tout(err_tout),
    .err_ovr(err_ovr), .busy(busy)
  );
  int checks = 0, errors = 0, cyc = 0, drv_cyc = 0, ok_cyc = 0, tout_cyc = 0;
  int n_ok = 0, n_len = 0, n_chk = 0, n_tout = 0, n_ovr = 0;
  int b_ok, b_len, b_chk, b_tout, b_ovr, gap = 0, mn;
  logic [7:0] frame[$], dq[$], seq[$], ms;
  logic [8:0] got[$];
  bit e_ok, e_len, e_chk, e_tout, e_ovr;
  logic p_hold = 0, p_last = 0;
  logic [7:0] p_data = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(posedge sys_clk) cyc <= cyc + 1;
  // frame model: bytes of the frame in progress and the payload still to be delivered
  always @(posedge sys_clk or posedge rst) begin
    {e_ok, e_len, e_chk, e_tout, e_ovr} = '0;
    if (rst) begin
      frame.delete();
      dq.delete();
      gap = 0;
    end else if (dq.size() != 0) begin
      if (rx_done) e_ovr = 1;
      if (out_ready) void'(dq.pop_front());
    end else if (frame.size() == 0) begin
      if (rx_done && rx_byte == 8'hA5) begin
        frame.push_back(rx_byte);
        gap = 0;
      end
    end else if (rx_done) begin
      frame.push_back(rx_byte);
      gap = 0;
      mn = int'(frame[1]);
      if (frame.size() == 2 && (mn == 0 || mn > MAXL)) begin
        e_len = 1;
        frame.delete();
      end else if (frame.size() == mn + 3) begin
        ms = 0;
        for (int i = 1; i <= mn + 1; i++) ms += frame[i];
        if (ms == rx_byte) begin
          e_ok = 1;
          for (int i = 2; i <= mn + 1; i++) dq.push_back(frame[i]);
        end else e_chk = 1;
        frame.delete();
      end
    end else begin
      gap++;
      if (gap == TOUT) begin
        e_tout = 1;
        frame.delete();
      end
    end
  end
  always @(negedge sys_clk) begin
    chk("busy", busy, (frame.size() != 0 || dq.size() != 0));
    chk("out_valid", out_valid, dq.size() != 0);
    if (dq.size() != 0) begin
      chk("out_data", out_data, dq[0]);
      chk("out_last", out_last, dq.size() == 1);
    end
    chk("frame_ok", frame_ok, e_ok);
    chk("err_len", err_len, e_len);
    chk("err_chk", err_chk, e_chk);
    chk("err_tout", err_tout, e_tout);
    chk("err_ovr", err_ovr, e_ovr);
    chk("pulse_excl", $onehot0({frame_ok, err_len, err_chk, err_tout, err_ovr}), 1);
    chk("last_needs_valid", !out_last || out_valid, 1);
    chk("valid_needs_busy", !out_valid || busy, 1);
    if (p_hold) begin
      chk("hold_data", out_data, p_data);
      chk("hold_last", out_last, p_last);
    end
    p_hold = out_valid && !out_ready;
    p_data = out_data;
    p_last = out_last;
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    if (frame_ok) begin n_ok++; ok_cyc = cyc; end
    if (err_len) n_len++;
    if (err_chk) n_chk++;
    if (err_tout) begin n_tout++; tout_cyc = cyc; end
    if (err_ovr) n_ovr++;
  end
  always @(posedge sys_clk) begin
    #1;
    out_ready = tog ? ~out_ready : 1'b1;
  end
  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1;
    drv_cyc = cyc;
    @(posedge sys_clk);
    #1;
    rx_done = 0;
    rx_byte = 8'hA5;
    idle(1);
  endtask
  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask
  task automatic mark();
    got.delete();
    b_ok = n_ok; b_len = n_len; b_chk = n_chk; b_tout = n_tout; b_ovr = n_ovr;
  endtask
  initial begin
    idle(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    rst = 0;
    idle(2);
    mark();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq();
    idle(6);
    chk("t1_ok_cnt", n_ok - b_ok, 1);
    chk("t1_ok_lat", ok_cyc - drv_cyc, 1);
    chk("t1_len", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_b0", got[0], 9'h011);
      chk("t1_b1", got[1], 9'h022);
      chk("t1_b2", got[2], 9'h133);
    end
    mark();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_seq();
    idle(4);
    chk("t2_chk_cnt", n_chk - b_chk, 1);
    chk("t2_no_out", got.size(), 0);
    chk("t2_idle", busy, 0);
    mark();
    seq = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(i[7:0]);
    seq.push_back(8'h88);
    send_seq();
    idle(20);
    chk("t3_len_cnt", n_len - b_len, 2);
    chk("t3_ok_cnt", n_ok - b_ok, 1);
    chk("t3_size", got.size(), 16);
    if (got.size() == 16) begin
      chk("t3_first", got[0], 9'h000);
      chk("t3_last", got[15], 9'h10F);
    end
    mark();
    seq = '{8'hA5, 8'h02, 8'h44};
    send_seq();
    idle(TOUT + 5);
    chk("t4_tout_cnt", n_tout - b_tout, 1);
    chk("t4_tout_gap", tout_cyc - drv_cyc, TOUT + 1);
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_seq();
    idle(3);
    chk("t4_size", got.size(), 1);
    if (got.size() == 1) chk("t4_b0", got[0], 9'h17E);
    mark();
    send(8'hA5);
    send(8'h02);
    idle(TOUT - 2);
    seq = '{8'h44, 8'h55, 8'h9B};
    send_seq();
    idle(4);
    chk("t4b_no_tout", n_tout - b_tout, 0);
    chk("t4b_ok", n_ok - b_ok, 1);
    mark();
    tog = 1;
    seq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09, 8'hA5};
    send_seq();
    idle(10);
    tog = 0;
    idle(1);
    send(8'h03);
    idle(3);
    chk("t5_ovr_cnt", n_ovr - b_ovr, 1);
    chk("t5_no_hunt", busy, 0);
    chk("t5_size", got.size(), 3);
    if (got.size() == 3) chk("t5_b2", got[2], 9'h103);
    mark();
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_seq();
    rst = 1;
    idle(2);
    chk("t6_rst_busy", busy, 0);
    rst = 0;
    idle(1);
    seq = '{8'h3C, 8'hA5, 8'h01, 8'h00, 8'h01, 8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_seq();
    idle(4);
    chk("t6_ok_cnt", n_ok - b_ok, 2);
    chk("t6_size", got.size(), 2);
    if (got.size() == 2) begin
      chk("t6_b0", got[0], 9'h100);
      chk("t6_b1", got[1], 9'h15A);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
